// File: rtl/recover_2n_feeder.sv
// recover_2n_feeder: frame sequencer feeding the 2N-point recombination core.
// Reads X1/X2 half-spectra beat by beat from synchronous RAMs, realigns the
// returned data with its address, and counts core results to end the frame.
module recover_2n_feeder #(
    parameter int DATA_WIDTH = 27,
    parameter int NUM_BEATS  = 256,
    parameter int RD_LAT     = 2,
    parameter int ADDR_W     = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        hold,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [7:0][DATA_WIDTH-1:0]  ram_x1_r,
    input  logic [7:0][DATA_WIDTH-1:0]  ram_x1_i,
    input  logic [7:0][DATA_WIDTH-1:0]  ram_x2_r,
    input  logic [7:0][DATA_WIDTH-1:0]  ram_x2_i,
    output logic                        valid,
    output logic [3:0][DATA_WIDTH-1:0]  x1_col1_r,
    output logic [3:0][DATA_WIDTH-1:0]  x1_col1_i,
    output logic [3:0][DATA_WIDTH-1:0]  x2_col1_r,
    output logic [3:0][DATA_WIDTH-1:0]  x2_col1_i,
    output logic [3:0][DATA_WIDTH-1:0]  x1_col2_r,
    output logic [3:0][DATA_WIDTH-1:0]  x1_col2_i,
    output logic [3:0][DATA_WIDTH-1:0]  x2_col2_r,
    output logic [3:0][DATA_WIDTH-1:0]  x2_col2_i,
    output logic [10:0]                 index_col_1,
    output logic [10:0]                 index_col_2,
    input  logic                        core_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(NUM_BEATS - 1);
    localparam logic [10:0]       BEATS     = 11'(NUM_BEATS);

    logic [1:0]                    state;
    logic [ADDR_W-1:0]             beat_cnt;
    logic [10:0]                   result_cnt;
    logic                          active;
    logic                          count_full;
    logic                          ready_ok;
    logic                          proto_err;
    logic [RD_LAT-1:0]             pipe_en;
    logic [RD_LAT-1:0][ADDR_W-1:0] pipe_addr;
    logic                          tail_en;
    logic [10:0]                   tail_index;

    assign rd_en   = (state == S_ISSUE) && !hold;
    assign rd_addr = beat_cnt;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_FIN);

    assign active     = (state == S_ISSUE) || (state == S_DRAIN);
    assign count_full = (result_cnt == BEATS);
    assign ready_ok   = core_ready && active && !count_full;
    assign proto_err  = core_ready && (!active || count_full);

    assign tail_en    = pipe_en[RD_LAT-1];
    assign tail_index = 11'({pipe_addr[RD_LAT-1], 1'b0});

    // Frame sequencing: issue reads, wait for all results, pulse done for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            beat_cnt   <= '0;
            result_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_ISSUE;
                        beat_cnt   <= '0;
                        result_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    if (rd_en) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (count_full || (ready_ok && (result_cnt == BEATS - 11'd1))) begin
                        state <= S_FIN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (ready_ok) begin
                result_cnt <= result_cnt + 11'd1;
            end
        end
    end

    // Sticky protocol error; a new error in the same cycle outranks the clear by start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (proto_err) begin
            err <= 1'b1;
        end else if ((state == S_IDLE) && start) begin
            err <= 1'b0;
        end
    end

    // Delay line matching the RAM latency so each returning word keeps its address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_en   <= '0;
            pipe_addr <= '0;
        end else begin
            pipe_en[0]   <= rd_en;
            pipe_addr[0] <= rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_en[i]   <= pipe_en[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    // Capture RAM lanes and column indices when the aligned read arrives; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= 1'b0;
            x1_col1_r   <= '0;
            x1_col1_i   <= '0;
            x2_col1_r   <= '0;
            x2_col1_i   <= '0;
            x1_col2_r   <= '0;
            x1_col2_i   <= '0;
            x2_col2_r   <= '0;
            x2_col2_i   <= '0;
            index_col_1 <= '0;
            index_col_2 <= '0;
        end else begin
            valid <= tail_en;
            if (tail_en) begin
                x1_col1_r   <= ram_x1_r[3:0];
                x1_col1_i   <= ram_x1_i[3:0];
                x2_col1_r   <= ram_x2_r[3:0];
                x2_col1_i   <= ram_x2_i[3:0];
                x1_col2_r   <= ram_x1_r[7:4];
                x1_col2_i   <= ram_x1_i[7:4];
                x2_col2_r   <= ram_x2_r[7:4];
                x2_col2_i   <= ram_x2_i[7:4];
                index_col_1 <= tail_index;
                index_col_2 <= tail_index | 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_recover_2n_feeder.sv
// Testbench for recover_2n_feeder: randomized hold/start/core_ready traffic
// checked cycle by cycle against a frame-level reference model.
module tb_recover_2n_feeder;

    localparam int DW  = 27;
    localparam int NB  = 4;
    localparam int RDL = 2;
    localparam int AW  = 10;

    logic clk = 1'b0;
    logic rst, start, hold, core_ready;
    logic busy, done, err, rd_en, valid;
    logic [AW-1:0] rd_addr;
    logic [7:0][DW-1:0] ram_x1_r, ram_x1_i, ram_x2_r, ram_x2_i;
    logic [3:0][DW-1:0] x1_col1_r, x1_col1_i, x2_col1_r, x2_col1_i;
    logic [3:0][DW-1:0] x1_col2_r, x1_col2_i, x2_col2_r, x2_col2_i;
    logic [10:0] index_col_1, index_col_2;

    // RAM contents and a two-stage synchronous read model
    logic [7:0][DW-1:0] mem_x1r[NB], mem_x1i[NB], mem_x2r[NB], mem_x2i[NB];
    logic [AW-1:0] ram_q1 = '0;
    logic [AW-1:0] ram_q2 = '0;

    // Reference model state
    int  reads, results;
    bit  in_frame, fin, err_m, known, addr_zero;
    bit  [RDL:0] rd_hist;
    int  addr_hist[RDL+1];
    bit  [5:0] rdy_hist;
    logic [3:0][DW-1:0] last_lane[8];
    logic [10:0] last_i1, last_i2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous RAM with two cycles of read latency
    always @(posedge clk) begin
        if (rd_en) ram_q1 <= rd_addr;
        ram_q2 <= ram_q1;
    end

    assign ram_x1_r = mem_x1r[ram_q2[1:0]];
    assign ram_x1_i = mem_x1i[ram_q2[1:0]];
    assign ram_x2_r = mem_x2r[ram_q2[1:0]];
    assign ram_x2_i = mem_x2i[ram_q2[1:0]];

    recover_2n_feeder #(
        .DATA_WIDTH(DW), .NUM_BEATS(NB), .RD_LAT(RDL), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .ram_x1_r(ram_x1_r), .ram_x1_i(ram_x1_i),
        .ram_x2_r(ram_x2_r), .ram_x2_i(ram_x2_i),
        .valid(valid),
        .x1_col1_r(x1_col1_r), .x1_col1_i(x1_col1_i),
        .x2_col1_r(x2_col1_r), .x2_col1_i(x2_col1_i),
        .x1_col2_r(x1_col2_r), .x1_col2_i(x1_col2_i),
        .x2_col2_r(x2_col2_r), .x2_col2_i(x2_col2_i),
        .index_col_1(index_col_1), .index_col_2(index_col_2),
        .core_ready(core_ready)
    );

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit expEn();
        return in_frame && !fin && (reads < NB) && !hold;
    endfunction

    // Compare every DUT output against what the frame model predicts for this cycle
    task automatic checkCycle();
        bit exp_en;
        bit exp_vld;
        int a;
        exp_en  = expEn();
        exp_vld = rd_hist[RDL];
        checkOutput("busy",  128'(busy),  128'(in_frame));
        checkOutput("done",  128'(done),  128'(fin));
        checkOutput("err",   128'(err),   128'(err_m));
        checkOutput("rd_en", 128'(rd_en), 128'(exp_en));
        checkOutput("valid", 128'(valid), 128'(exp_vld));
        if (exp_en || addr_zero)
            checkOutput("rd_addr", 128'(rd_addr), 128'(reads));
        if (exp_vld) begin
            a = addr_hist[RDL];
            last_lane[0] = mem_x1r[a][3:0];
            last_lane[1] = mem_x1i[a][3:0];
            last_lane[2] = mem_x2r[a][3:0];
            last_lane[3] = mem_x2i[a][3:0];
            last_lane[4] = mem_x1r[a][7:4];
            last_lane[5] = mem_x1i[a][7:4];
            last_lane[6] = mem_x2r[a][7:4];
            last_lane[7] = mem_x2i[a][7:4];
            last_i1 = 11'(2 * a);
            last_i2 = 11'(2 * a + 1);
        end
        checkOutput("x1_col1_r", 128'(x1_col1_r), 128'(last_lane[0]));
        checkOutput("x1_col1_i", 128'(x1_col1_i), 128'(last_lane[1]));
        checkOutput("x2_col1_r", 128'(x2_col1_r), 128'(last_lane[2]));
        checkOutput("x2_col1_i", 128'(x2_col1_i), 128'(last_lane[3]));
        checkOutput("x1_col2_r", 128'(x1_col2_r), 128'(last_lane[4]));
        checkOutput("x1_col2_i", 128'(x1_col2_i), 128'(last_lane[5]));
        checkOutput("x2_col2_r", 128'(x2_col2_r), 128'(last_lane[6]));
        checkOutput("x2_col2_i", 128'(x2_col2_i), 128'(last_lane[7]));
        checkOutput("index_col_1", 128'(index_col_1), 128'(last_i1));
        checkOutput("index_col_2", 128'(index_col_2), 128'(last_i2));
    endtask

    // Advance the frame model by one clock using this cycle's inputs
    task automatic modelStep();
        bit en, vld, idle, err_set, accept, drain;
        int rb;
        if (rst) begin
            in_frame = 0; fin = 0; reads = 0; results = 0; err_m = 0;
            rd_hist = '0; rdy_hist = '0; addr_zero = 1; known = 1;
            for (int i = 0; i < 8; i++) last_lane[i] = '0;
            for (int i = 0; i <= RDL; i++) addr_hist[i] = 0;
            last_i1 = '0; last_i2 = '0;
            return;
        end
        en    = expEn();
        vld   = rd_hist[RDL];
        idle  = !in_frame;
        rb    = reads;
        drain = in_frame && !fin && (reads == NB);
        err_set = core_ready && (!(in_frame && !fin) || (results == NB));
        if (core_ready && !err_set) results++;
        if (fin) begin
            in_frame = 0;
            fin = 0;
        end else if (drain && (results == NB)) begin
            fin = 1;
        end
        if (en) reads++;
        accept = idle && start;
        if (accept) begin
            in_frame = 1; reads = 0; results = 0; addr_zero = 0;
        end
        err_m = err_set ? 1'b1 : (accept ? 1'b0 : err_m);
        rd_hist = {rd_hist[RDL-1:0], en};
        for (int i = RDL; i > 0; i--) addr_hist[i] = addr_hist[i-1];
        addr_hist[0] = rb;
        rdy_hist = {rdy_hist[4:0], vld};
    endtask

    // One clock: drive inputs, check at the falling edge, step the model at the rising edge
    task automatic applyStimulus(input logic st, input logic hd, input logic rs, input logic xr);
        start = st;
        hold  = hd;
        rst   = rs;
        core_ready = rdy_hist[5] | xr;
        @(negedge clk);
        if (known) checkCycle();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // Run one frame from a start pulse until the model returns to idle
    task automatic runFrame(input logic [31:0] hold_mask, input logic [31:0] start_mask, input bit extra_in_fin);
        int k;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        k = 1;
        while (in_frame && k < 200) begin
            applyStimulus((k < 32) ? start_mask[k] : 1'b0,
                          (k < 32) ? hold_mask[k]  : 1'b0,
                          1'b0, extra_in_fin && fin);
            k++;
        end
        checkOutput("frame_end", 128'(in_frame), 128'(0));
    endtask

    initial begin
        start = 0; hold = 0; rst = 1; core_ready = 0;
        known = 0; rd_hist = '0; rdy_hist = '0;
        for (int a = 0; a < NB; a++) begin
            for (int l = 0; l < 8; l++) begin
                mem_x1r[a][l] = DW'($urandom);
                mem_x1i[a][l] = DW'($urandom);
                mem_x2r[a][l] = DW'($urandom);
                mem_x2i[a][l] = DW'($urandom);
            end
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] plain frame");
        runFrame(32'h0, 32'h0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] frame with hold on 2nd and 3rd issue cycles");
        runFrame(32'hC, 32'h0, 1'b0);

        $display("[TB] start pulses during issue and drain");
        runFrame(32'h0, 32'h104, 1'b0);

        $display("[TB] reset two cycles after first read");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        runFrame(32'h0, 32'h0, 1'b0);

        $display("[TB] protocol errors");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        runFrame(32'h0, 32'h0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] back-to-back frames");
        runFrame(32'h0, 32'h0, 1'b0);
        runFrame(32'h0, 32'h0, 1'b0);

        $display("[TB] randomized frames");
        repeat (16) begin
            runFrame($urandom & $urandom, $urandom & $urandom & $urandom,
                     ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
